blake2_pmod_host: RTL and testbench

//  Host-side end of the Blake2 PMOD link: drives data/data_ctrl into the hash device and collects hash/hash_ctrl back.

---
 rtl/blake2_pmod_host.sv | 195 +++++++++++++++++++
 tb/tb_blake2_pmod_host.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_pmod_host.sv
// Host end of the Blake2 PMOD link: sends config bytes and the message, then collects the hash.
// Latency: start -> first cfg byte >= 1 cycle; hash byte in -> hash_valid_o 3 cycles.
// Backpressure: bytes leave only when synced device ready is high and the per-byte holdoff has expired.
module blake2_pmod_host #(
    parameter int PMOD_W    = 8,
    parameter int HOLDOFF   = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        kk_i,
    input  logic [7:0]        nn_i,
    input  logic              msg_valid_i,
    input  logic [PMOD_W-1:0] msg_data_i,
    input  logic              msg_last_i,
    output logic              msg_ready_o,
    output logic [PMOD_W-1:0] data_o,
    output logic [2:0]        data_ctrl_o,
    input  logic [1:0]        hash_ctrl_i,
    input  logic [PMOD_W-1:0] hash_i,
    output logic              hash_valid_o,
    output logic [PMOD_W-1:0] hash_data_o,
    output logic              hash_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam int HOLD_W = $clog2(HOLDOFF + 2);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF);
    // Watchdog fires on the cycle the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_MSG,
        S_WAIT,
        S_HASH
    } state_t;

    state_t              r_state;
    logic [7:0]          r_kk;
    logic [7:0]          r_nn;
    logic                r_cfg_sel;
    logic [HOLD_W-1:0]   r_hold;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [6:0]          r_cnt;

    logic [1:0]          r_ctrl_s1;
    logic [1:0]          r_ctrl_s2;
    logic [PMOD_W-1:0]   r_hash_s1;
    logic [PMOD_W-1:0]   r_hash_s2;

    logic [PMOD_W-1:0]   r_data;
    logic [2:0]          r_data_ctrl;
    logic                r_hash_vld;
    logic [PMOD_W-1:0]   r_hash_dat;
    logic                r_hash_last;
    logic                r_done;
    logic                r_timeout;

    logic                w_ready_s;
    logic                w_hvalid_s;
    logic                w_can_send;
    logic                w_msg_take;
    logic                w_hash_final;
    logic                w_wd_expire;
    logic [7:0]          w_nn_clamped;

    assign w_ready_s    = r_ctrl_s2[0];
    assign w_hvalid_s   = r_ctrl_s2[1];
    assign w_can_send   = w_ready_s && (r_hold == '0);
    assign w_msg_take   = (r_state == S_MSG) && w_can_send && msg_valid_i;
    assign w_hash_final = ({1'b0, r_cnt} == (r_nn - 8'd1));
    assign w_wd_expire  = (r_wd == WD_LAST);
    // Illegal hash lengths (0 or > 64) fall back to the maximum digest size.
    assign w_nn_clamped = ((nn_i == 8'd0) || (nn_i > 8'd64)) ? 8'd64 : nn_i;

    assign msg_ready_o  = w_msg_take;
    assign data_o       = r_data;
    assign data_ctrl_o  = r_data_ctrl;
    assign hash_valid_o = r_hash_vld;
    assign hash_data_o  = r_hash_dat;
    assign hash_last_o  = r_hash_last;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;

    // Two-stage synchroniser for everything coming back from the device.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_s1 <= '0;
            r_ctrl_s2 <= '0;
            r_hash_s1 <= '0;
            r_hash_s2 <= '0;
        end else begin
            r_ctrl_s1 <= hash_ctrl_i;
            r_ctrl_s2 <= r_ctrl_s1;
            r_hash_s1 <= hash_i;
            r_hash_s2 <= r_hash_s1;
        end
    end

    // Job FSM with holdoff pacing, watchdog and registered link/hash outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_kk        <= '0;
            r_nn        <= '0;
            r_cfg_sel   <= 1'b0;
            r_hold      <= '0;
            r_wd        <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_data_ctrl <= '0;
            r_hash_vld  <= 1'b0;
            r_hash_dat  <= '0;
            r_hash_last <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // Pulsed outputs default low; done trails the last hash byte by one cycle.
            r_data_ctrl <= '0;
            r_hash_vld  <= 1'b0;
            r_hash_last <= 1'b0;
            r_done      <= r_hash_last;
            if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_kk      <= kk_i;
                        r_nn      <= w_nn_clamped;
                        r_timeout <= 1'b0;
                        r_cfg_sel <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_CFG;
                    end
                end

                S_CFG: begin
                    if (w_can_send) begin
                        r_data      <= r_cfg_sel ? PMOD_W'(r_nn) : PMOD_W'(r_kk);
                        r_data_ctrl <= 3'b001;
                        r_hold      <= HOLD_LOAD;
                        r_cfg_sel   <= 1'b1;
                        if (r_cfg_sel) begin
                            r_state <= S_MSG;
                        end
                    end
                end

                S_MSG: begin
                    if (w_msg_take) begin
                        r_data      <= msg_data_i;
                        r_data_ctrl <= {(msg_last_i ? 2'b10 : 2'b01), 1'b1};
                        r_hold      <= HOLD_LOAD;
                        if (msg_last_i) begin
                            r_wd    <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                end

                // WAIT and HASH share handling: a byte can arrive on the very first WAIT cycle.
                S_WAIT, S_HASH: begin
                    if (w_hvalid_s) begin
                        r_hash_vld <= 1'b1;
                        r_hash_dat <= r_hash_s2;
                        r_wd       <= '0;
                        if (w_hash_final) begin
                            r_hash_last <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 7'd1;
                            r_state <= S_HASH;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + TIMEOUT_W'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_pmod_host.sv
// Directed bench for blake2_pmod_host: config, message pacing, hash capture, timeout, reset, edge cases.
// The DUT uses a 4-bit watchdog so the timeout path is reachable in a short run.
// Inputs change on the falling edge; outputs are logged 3 ns after the falling edge.
module tb_blake2_pmod_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] kk_i = '0;
    logic [7:0] nn_i = '0;
    logic       msg_valid_i = 1'b0;
    logic [7:0] msg_data_i = '0;
    logic       msg_last_i = 1'b0;
    logic       msg_ready_o;
    logic [7:0] data_o;
    logic [2:0] data_ctrl_o;
    logic [1:0] hash_ctrl_i;
    logic [7:0] hash_i;
    logic       hash_valid_o;
    logic [7:0] hash_data_o;
    logic       hash_last_o;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;

    logic       dev_rdy = 1'b1;
    logic       dev_hv = 1'b0;
    logic [7:0] dev_hash = '0;

    assign hash_ctrl_i = {dev_hv, dev_rdy};
    assign hash_i      = dev_hash;

    blake2_pmod_host #(.PMOD_W(8), .HOLDOFF(4), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
        .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
        .msg_ready_o(msg_ready_o), .data_o(data_o), .data_ctrl_o(data_ctrl_o),
        .hash_ctrl_i(hash_ctrl_i), .hash_i(hash_i), .hash_valid_o(hash_valid_o),
        .hash_data_o(hash_data_o), .hash_last_o(hash_last_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] dat; logic [1:0] cmd; } lane_t;
    typedef struct { int cyc; logic [7:0] dat; logic last; } hrec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    logic  rs1 = 1'b0;
    logic  rs2 = 1'b0;
    lane_t lane_q[$];
    hrec_t hash_q[$];
    int    done_q[$];
    int    mrdy_cnt = 0;
    int    viol_cnt = 0;
    logic [7:0] msg_buf [0:7];

    // Cycle counter and the bench's view of what ready looks like after two sync flops.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rs1 <= 1'b0;
            rs2 <= 1'b0;
        end else begin
            rs1 <= dev_rdy;
            rs2 <= rs1;
        end
    end

    // Output logger.
    always @(negedge clk) begin
        lane_t l;
        hrec_t h;
        #3;
        if (data_ctrl_o[0]) begin
            l.cyc = cyc; l.dat = data_o; l.cmd = data_ctrl_o[2:1];
            lane_q.push_back(l);
        end
        if (msg_ready_o) begin
            mrdy_cnt++;
            if (!rs2) viol_cnt++;
        end
        if (hash_valid_o) begin
            h.cyc = cyc; h.dat = hash_data_o; h.last = hash_last_o;
            hash_q.push_back(h);
        end
        if (done_o) done_q.push_back(cyc);
    end

    task automatic launch(input logic [7:0] kk, input logic [7:0] nn);
        kk_i = kk; nn_i = nn; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Presents msg_buf[0..n-1]; optionally drops device ready for gap cycles after the first byte.
    task automatic send_msg(input int n, input int gap);
        int   idx = 0;
        int   budget = 300;
        int   gap_left = 0;
        logic take;
        while (idx < n && budget > 0) begin
            msg_valid_i = 1'b1;
            msg_data_i  = msg_buf[idx];
            msg_last_i  = (idx == n - 1);
            #3;
            take = msg_ready_o;
            @(negedge clk);
            budget--;
            if (take) begin
                idx++;
                if (gap > 0 && idx == 1) begin
                    dev_rdy = 1'b0;
                    gap_left = gap;
                end
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) dev_rdy = 1'b1;
            end
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        dev_rdy     = 1'b1;
        if (idx < n) begin
            checks++; errors++;
            $display("FAIL send_msg: consumed %0d bytes, required %0d", idx, n);
        end
    endtask

    task automatic wait_lane(input int want);
        int n = 0;
        while (lane_q.size() < want && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (lane_q.size() < want) begin
            checks++; errors++;
            $display("FAIL wait_lane: got %0d lane bytes, required %0d", lane_q.size(), want);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (data_ctrl_o !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b, required 000", data_ctrl_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, required 0", timeout_o); end
        checks++; if (hash_valid_o !== 1'b0) begin errors++; $display("FAIL rst_hvalid: got %b, required 0", hash_valid_o); end
        checks++; if (msg_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mrdy: got %b, required 0", msg_ready_o); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_config;
        lane_q.delete();
        done_q.delete();
        launch(8'h00, 8'd32);
        wait_lane(2);
        @(negedge clk);
        checks++; if (lane_q.size() !== 2) begin errors++; $display("FAIL cfg_count: got %0d, required 2", lane_q.size()); end
        if (lane_q.size() >= 2) begin
            checks++; if (lane_q[0].dat !== 8'h00 || lane_q[0].cmd !== 2'b00) begin
                errors++; $display("FAIL cfg_byte0: got %h/%b, required 00/00", lane_q[0].dat, lane_q[0].cmd); end
            checks++; if (lane_q[1].dat !== 8'h20 || lane_q[1].cmd !== 2'b00) begin
                errors++; $display("FAIL cfg_byte1: got %h/%b, required 20/00", lane_q[1].dat, lane_q[1].cmd); end
            checks++; if (lane_q[1].cyc - lane_q[0].cyc !== 5) begin
                errors++; $display("FAIL cfg_spacing: got %0d, required 5", lane_q[1].cyc - lane_q[0].cyc); end
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cfg_busy: got %b, required 1", busy_o); end
    endtask

    task automatic test_message;
        logic [7:0] exp_d [0:2];
        logic [1:0] exp_c [0:2];
        exp_d[0] = 8'h61; exp_d[1] = 8'h62; exp_d[2] = 8'h63;
        exp_c[0] = 2'b01; exp_c[1] = 2'b01; exp_c[2] = 2'b10;
        lane_q.delete();
        mrdy_cnt = 0;
        viol_cnt = 0;
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
        send_msg(3, 10);
        #4;
        checks++; if (mrdy_cnt !== 3) begin errors++; $display("FAIL msg_ready_count: got %0d, required 3", mrdy_cnt); end
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL msg_ready_not_ready: got %0d pulses, required 0", viol_cnt); end
        checks++; if (lane_q.size() !== 3) begin errors++; $display("FAIL msg_lane_count: got %0d, required 3", lane_q.size()); end
        for (int i = 0; i < 3 && i < lane_q.size(); i++) begin
            checks++; if (lane_q[i].dat !== exp_d[i] || lane_q[i].cmd !== exp_c[i]) begin
                errors++; $display("FAIL msg_byte%0d: got %h/%b, required %h/%b", i, lane_q[i].dat, lane_q[i].cmd, exp_d[i], exp_c[i]); end
        end
        if (lane_q.size() >= 2) begin
            checks++; if (lane_q[1].cyc - lane_q[0].cyc < 10) begin
                errors++; $display("FAIL msg_ready_gap: got spacing %0d, required >= 10", lane_q[1].cyc - lane_q[0].cyc); end
        end
    endtask

    task automatic test_timeout;
        int last_cyc;
        int n = 0;
        last_cyc = (lane_q.size() > 0) ? lane_q[lane_q.size()-1].cyc : cyc;
        while (timeout_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_flag: got %b, required 1", timeout_o); end
        checks++; if (cyc - last_cyc !== 15) begin errors++; $display("FAIL to_cycles: got %0d, required 15", cyc - last_cyc); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL to_busy: got %b, required 0", busy_o); end
        repeat (4) @(negedge clk);
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b, required 1", timeout_o); end
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL to_no_done: got %0d pulses, required 0", done_q.size()); end
    endtask

    task automatic test_hash;
        logic [7:0] hb [0:4];
        int gap [0:4];
        int in_cyc [0:4];
        hb[0] = 8'hBA; hb[1] = 8'h80; hb[2] = 8'hA5; hb[3] = 8'h3F; hb[4] = 8'h11;
        gap[0] = 0; gap[1] = 1; gap[2] = 3; gap[3] = 1; gap[4] = 0;
        hash_q.delete();
        done_q.delete();
        launch(8'h00, 8'd4);
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL hash_to_clear: got %b, required 0", timeout_o); end
        msg_buf[0] = 8'h61;
        send_msg(1, 0);
        for (int i = 0; i < 5; i++) begin
            dev_hv = 1'b1; dev_hash = hb[i]; in_cyc[i] = cyc;
            @(negedge clk);
            dev_hv = 1'b0;
            repeat (gap[i]) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        #4;
        checks++; if (hash_q.size() !== 4) begin errors++; $display("FAIL hash_count: got %0d, required 4", hash_q.size()); end
        for (int i = 0; i < 4 && i < hash_q.size(); i++) begin
            checks++; if (hash_q[i].dat !== hb[i]) begin
                errors++; $display("FAIL hash_data%0d: got %h, required %h", i, hash_q[i].dat, hb[i]); end
            checks++; if (hash_q[i].cyc - in_cyc[i] !== 3) begin
                errors++; $display("FAIL hash_latency%0d: got %0d, required 3", i, hash_q[i].cyc - in_cyc[i]); end
            checks++; if (hash_q[i].last !== (i == 3)) begin
                errors++; $display("FAIL hash_last%0d: got %b, required %b", i, hash_q[i].last, (i == 3)); end
        end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL hash_done_count: got %0d, required 1", done_q.size()); end
        if (done_q.size() >= 1 && hash_q.size() >= 4) begin
            checks++; if (done_q[0] !== hash_q[3].cyc + 1) begin
                errors++; $display("FAIL hash_done_cycle: got %0d, required %0d", done_q[0], hash_q[3].cyc + 1); end
        end
        checks++; if (busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL hash_end_state: got busy=%b to=%b, required 0/0", busy_o, timeout_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n0;
        int m0;
        lane_q.delete();
        launch(8'h01, 8'd8);
        wait_lane(2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (data_ctrl_o !== 3'b000) begin errors++; $display("FAIL rstm_ctrl: got %b, required 000", data_ctrl_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstm_busy: got %b, required 0", busy_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rstm_data: got %h, required 00", data_o); end
        checks++; if (done_o !== 1'b0 || timeout_o !== 1'b0 || hash_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstm_flags: got done=%b to=%b hv=%b, required 0/0/0", done_o, timeout_o, hash_valid_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        n0 = lane_q.size();
        m0 = mrdy_cnt;
        @(negedge clk);
        msg_valid_i = 1'b1; msg_data_i = 8'h99; msg_last_i = 1'b1;
        repeat (20) @(negedge clk);
        msg_valid_i = 1'b0; msg_last_i = 1'b0;
        #4;
        checks++; if (lane_q.size() !== n0) begin errors++; $display("FAIL rstm_no_lane: got %0d bytes, required %0d", lane_q.size(), n0); end
        checks++; if (mrdy_cnt !== m0) begin errors++; $display("FAIL rstm_no_mrdy: got %0d, required %0d", mrdy_cnt, m0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstm_idle: got %b, required 0", busy_o); end
        @(negedge clk);
    endtask

    task automatic test_edge;
        int n = 0;
        lane_q.delete();
        done_q.delete();
        launch(8'h05, 8'd0);
        kk_i = 8'h77; nn_i = 8'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_lane(2);
        msg_buf[0] = 8'h55;
        send_msg(1, 0);
        #4;
        checks++; if (lane_q.size() !== 3) begin errors++; $display("FAIL edge_count: got %0d, required 3", lane_q.size()); end
        if (lane_q.size() >= 3) begin
            checks++; if (lane_q[0].dat !== 8'h05) begin errors++; $display("FAIL edge_kk: got %h, required 05", lane_q[0].dat); end
            checks++; if (lane_q[1].dat !== 8'h40 || lane_q[1].cmd !== 2'b00) begin
                errors++; $display("FAIL edge_nn_clamp: got %h/%b, required 40/00", lane_q[1].dat, lane_q[1].cmd); end
            checks++; if (lane_q[2].dat !== 8'h55 || lane_q[2].cmd !== 2'b10) begin
                errors++; $display("FAIL edge_one_byte: got %h/%b, required 55/10", lane_q[2].dat, lane_q[2].cmd); end
        end
        while (busy_o === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
            errors++; $display("FAIL edge_end: got busy=%b to=%b, required 0/1", busy_o, timeout_o); end
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL edge_no_done: got %0d, required 0", done_q.size()); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_message();
        test_timeout();
        test_hash();
        test_reset_mid();
        test_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
